// File: rtl/icache_refill_master.sv
// Refill master for the I-cache: fetches one BEATS x 128-bit line over the LINT read channel,
// keeps up to MAX_OUTSTANDING reads in flight and assembles the responses in issue order.
module icache_refill_master #(
  parameter int ADDR_WIDTH      = 16,
  parameter int BEATS           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   refill_req_i,
  output logic                   refill_gnt_o,
  input  logic [ADDR_WIDTH-1:0]  refill_addr_i,
  output logic                   refill_done_o,
  output logic [ADDR_WIDTH-1:0]  refill_line_addr_o,
  output logic [BEATS*128-1:0]   refill_line_o,
  output logic                   lint_req_o,
  output logic [ADDR_WIDTH-1:0]  lint_addr_o,
  input  logic                   lint_grant_i,
  input  logic [3:0][31:0]       lint_r_rdata_i,
  input  logic                   lint_r_valid_i
);

  localparam int CW = $clog2(BEATS + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           received_q, received_d;
  logic [OW-1:0]           outst_q, outst_d;
  logic [ADDR_WIDTH-1:0]   base_d, addr_d;
  logic                    req_d;
  logic                    issue, resp;
  logic [SW-1:0]           slot;
  logic [BEATS-1:0][127:0] line_q;

  assign refill_gnt_o  = (state_q == IDLE);
  assign refill_done_o = (state_q == DONE);
  assign refill_line_o = line_q;

  // Bus events only count in BUSY; stray grants/responses elsewhere are dropped.
  assign issue = (state_q == BUSY) && lint_req_o && lint_grant_i;
  assign resp  = (state_q == BUSY) && lint_r_valid_i;
  assign slot  = received_q[SW-1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can leave it unassigned and infer a latch.
    state_d    = state_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;
    base_d     = refill_line_addr_o;
    unique case (state_q)
      IDLE: begin
        if (refill_req_i) begin
          state_d    = BUSY;
          base_d     = refill_addr_i & ALIGN_MASK;
          issued_d   = '0;
          received_d = '0;
          outst_d    = '0;
        end
      end
      BUSY: begin
        issued_d   = issued_q + CW'(issue);
        received_d = received_q + CW'(resp);
        outst_d    = outst_q + OW'(issue) - OW'(resp);
        if (received_d == CW'(BEATS)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request and address are registered, so they are decided from next-cycle counter values.
    req_d  = (state_d == BUSY) && (issued_d < CW'(BEATS)) && (outst_d < OW'(MAX_OUTSTANDING));
    addr_d = (state_d == BUSY) ? base_d + ADDR_WIDTH'(issued_d) : lint_addr_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      issued_q           <= '0;
      received_q         <= '0;
      outst_q            <= '0;
      lint_req_o         <= 1'b0;
      lint_addr_o        <= '0;
      refill_line_addr_o <= '0;
      // NOTE: the line buffer is reset along with the control state because it is visible on refill_line_o, which must read 0 after reset.
      line_q             <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
      state_q            <= state_d;
      issued_q           <= issued_d;
      received_q         <= received_d;
      outst_q            <= outst_d;
      lint_req_o         <= req_d;
      lint_addr_o        <= addr_d;
      refill_line_addr_o <= base_d;
      if (resp) line_q[slot] <= lint_r_rdata_i;
    end
  end

endmodule

// File: doc/icache_refill_master.md
# icache_refill_master

Initiator side of the 128-bit instruction-bus read channel used between the hierarchical I-cache and its backing memory. On an upstream refill request it fetches one cache line of `BEATS` consecutive 128-bit words over the req/grant/addr, r_valid/r_rdata interface. It keeps up to `MAX_OUTSTANDING` reads in flight, assembles the line in order and presents it to the cache with a one-cycle done pulse. It sits between the cache miss handler and the instruction interconnect or memory responder.

## Interface
- `ADDR_WIDTH`, 16, width of the 128-bit-word address on both sides.
- `BEATS`, 2, 128-bit words per line; power of 2, range 1..8.
- `MAX_OUTSTANDING`, 2, maximum issued-but-unanswered reads; range 1..BEATS.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `refill_req_i` in 1: upstream refill request.
- `refill_gnt_o` out 1: request accepted this cycle.
- `refill_addr_i` in ADDR_WIDTH: word address of the line; the low log2(BEATS) bits are ignored (forced 0).
- `refill_done_o` out 1: one-cycle pulse, line complete.
- `refill_line_addr_o` out ADDR_WIDTH: aligned base address of the completed line.
- `refill_line_o` out BEATS×128: assembled line, beat k at bits [128k+127:128k].
- `lint_req_o` out 1: bus read request.
- `lint_addr_o` out ADDR_WIDTH: bus word address.
- `lint_grant_i` in 1: bus grant. A beat is issued in a cycle where `lint_req_o & lint_grant_i`.
- `lint_r_rdata_i` in [3:0][31:0]: read data.
- `lint_r_valid_i` in 1: read response valid. Responses arrive in issue order, at least 1 cycle after the grant.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `refill_gnt_o = 1`.
  - On `refill_req_i`: latch the aligned base address, clear the issue and receive counters, go to BUSY.
- **BUSY**
  - `lint_req_o = 1` while issued < BEATS and outstanding < MAX_OUTSTANDING.
  - `lint_addr_o = base + issued`. This never wraps, because the base is aligned.
  - While the grant is low, `lint_req_o` stays high and `lint_addr_o` holds its value.
  - Each grant increments issued. Each `lint_r_valid_i` writes `lint_r_rdata_i` to beat slot received, then increments received.
  - outstanding = issued − received, held in a register. A grant and a response in the same cycle leave outstanding unchanged.
  - When received reaches BEATS, go to DONE.
- **DONE**
  - `refill_done_o = 1` for exactly one cycle, then return to IDLE.
  - `refill_gnt_o = 0` in BUSY and DONE. The earliest next acceptance is the cycle after DONE.
- `refill_line_o` and `refill_line_addr_o` hold their values until the next refill's first response or acceptance overwrites them.
- `lint_r_valid_i` in IDLE or DONE (stray, e.g. after a reset mid-refill) is dropped. No state changes.
- `lint_grant_i` while `lint_req_o = 0` is ignored.
- Reset, at any time: FSM goes to IDLE and counters clear. `lint_req_o`, `refill_done_o`, `refill_line_o` and `refill_line_addr_o` are 0. `refill_gnt_o` is 1 (IDLE). `lint_addr_o` is 0.

## Timing
- Cycle 0: refill accepted.
- Cycle 1: first `lint_req_o`.
- Example: responder always grants, 1-cycle latency, BEATS=2, MAX_OUTSTANDING=2.
  - Issues at cycles 1 and 2; responses at cycles 2 and 3.
  - `refill_done_o` at cycle 4.
- General case, full grant and 1-cycle latency: done at cycle BEATS+2.
- With MAX_OUTSTANDING=1 and 1-cycle latency: one issue every 2 cycles; done at cycle 2·BEATS+1.
- `lint_req_o` and `lint_addr_o` are registered outputs. `refill_gnt_o` and `refill_done_o` are decoded from the state register.

## Test plan
- **Basic refill:** BEATS=2; memory word i = {i·16+C, +8, +4, +0}; refill at address 0x0013.
  - Bus addresses 0x0012 then 0x0013.
  - Done at cycle 4.
  - `refill_line_addr_o` = 0x0012; line beats = word 0x12, word 0x13.
- **Random grant stall:** grant low for 3 cycles on beat 1.
  - Address 0x0013 is held stable with req high throughout.
  - Data matches the basic refill; done 3 cycles later.
- **Outstanding limit:** MAX_OUTSTANDING=1, BEATS=4, response latency 3.
  - At most one unanswered issue at any time.
  - Done at cycle 1 + 4·4 = 17 after acceptance, counted from the first issue plus final register.
  - Scoreboard checks the ordering.
- **Back-to-back refills:** `refill_req_i` held high with addresses 0x0020 then 0x0040.
  - Grant low during BUSY and DONE.
  - Second grant the cycle after the first done; two done pulses with correct lines.
- **Reset mid-refill:** assert `rst_n` low after 1 of 2 beats, with a response arriving after release.
  - All outputs at reset values.
  - The stray r_valid is ignored.
  - A following refill to 0x0000 completes correctly.
